// File: rtl/microwave_cook_sequencer.sv
// rtl/microwave_cook_sequencer.sv - keypad-set BCD countdown cooking controller
module microwave_cook_sequencer #(
    parameter int unsigned DONE_BEEP_SECS  = 3,
    parameter logic [15:0] QUICK_START_BCD = 16'h0030
) (
    input  logic        in_clock,
    input  logic        in_reset_n,
    input  logic        in_sec_clock,
    input  logic        in_digit_valid,
    input  logic [3:0]  in_digit,
    input  logic        in_start,
    input  logic        in_stop,
    input  logic        in_door_closed,
    output logic [15:0] out_time,
    output logic        out_magnetron_on,
    output logic        out_done,
    output logic [2:0]  out_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_COOKING = 3'd2,
        S_PAUSED  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [3:0] BEEP_LAST = 4'(DONE_BEEP_SECS);

    state_t      state, state_nx;
    logic [15:0] time_q, time_nx, time_dec, digit_base;
    logic        done_q, done_nx;
    logic [3:0]  beep_q, beep_nx;
    logic        sec_prev;
    logic        tick;
    logic        start_ok;
    logic        digit_ok;

    assign tick = in_sec_clock & ~sec_prev;

    // Start is honoured from IDLE (quick start) or from ENTRY/PAUSED with a nonzero setpoint
    assign start_ok = in_start && in_door_closed &&
                      ((state == S_IDLE) ||
                       (((state == S_ENTRY) || (state == S_PAUSED)) && (time_q != 16'h0000)));

    assign digit_ok = in_digit_valid && (in_digit <= 4'd9) &&
                      ((state == S_IDLE) || (state == S_ENTRY) || (state == S_DONE));

    // A digit typed over a finished cycle starts a fresh setpoint
    assign digit_base = (state == S_DONE) ? 16'h0000 : time_q;

    // One-second BCD decrement; seconds tens wrap to 5 so entries like 0:90 still count down sanely
    always_comb begin
        time_dec = time_q;
        if (time_q[3:0] != 4'd0) begin
            time_dec[3:0] = time_q[3:0] - 4'd1;
        end else begin
            time_dec[3:0] = 4'd9;
            if (time_q[7:4] != 4'd0) begin
                time_dec[7:4] = time_q[7:4] - 4'd1;
            end else begin
                time_dec[7:4] = 4'd5;
                if (time_q[11:8] != 4'd0) begin
                    time_dec[11:8] = time_q[11:8] - 4'd1;
                end else begin
                    time_dec[11:8]  = 4'd9;
                    time_dec[15:12] = time_q[15:12] - 4'd1;
                end
            end
        end
    end

    // Next-state: one event per cycle in order stop, door open, start, tick, digit
    always_comb begin
        state_nx = state;
        time_nx  = time_q;
        done_nx  = done_q;
        beep_nx  = beep_q;
        if (in_stop) begin
            if (state == S_COOKING) begin
                state_nx = S_PAUSED;
            end else if (state != S_IDLE) begin
                state_nx = S_IDLE;
                time_nx  = 16'h0000;
                done_nx  = 1'b0;
                beep_nx  = 4'd0;
            end
        end else if ((state == S_COOKING) && !in_door_closed) begin
            state_nx = S_PAUSED;
        end else if (start_ok) begin
            state_nx = S_COOKING;
            if (state == S_IDLE) begin
                time_nx = QUICK_START_BCD;
            end
        end else if (tick && (state == S_COOKING)) begin
            time_nx = time_dec;
            if (time_dec == 16'h0000) begin
                state_nx = S_DONE;
                done_nx  = 1'b1;
                beep_nx  = 4'd0;
            end
        end else if (tick && (state == S_DONE)) begin
            if (4'(beep_q + 4'd1) >= BEEP_LAST) begin
                state_nx = S_IDLE;
                done_nx  = 1'b0;
                beep_nx  = 4'd0;
            end else begin
                beep_nx = beep_q + 4'd1;
            end
        end else if (digit_ok) begin
            state_nx = S_ENTRY;
            time_nx  = {digit_base[11:0], in_digit};
            done_nx  = 1'b0;
            beep_nx  = 4'd0;
        end
    end

    // State registers; sec_prev resets high so a seconds clock already high is not a tick
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state    <= S_IDLE;
            time_q   <= 16'h0000;
            done_q   <= 1'b0;
            beep_q   <= 4'd0;
            sec_prev <= 1'b1;
        end else begin
            state    <= state_nx;
            time_q   <= time_nx;
            done_q   <= done_nx;
            beep_q   <= beep_nx;
            sec_prev <= in_sec_clock;
        end
    end

    assign out_time         = time_q;
    assign out_done         = done_q;
    assign out_state        = state;
    assign out_magnetron_on = (state == S_COOKING) && in_door_closed;

endmodule

// File: tb/tb_microwave_cook_sequencer.sv
// tb/tb_microwave_cook_sequencer.sv - scoreboard bench for microwave_cook_sequencer
module tb_microwave_cook_sequencer;

    logic        in_clock = 1'b0;
    logic        in_reset_n = 1'b0;
    logic        in_sec_clock = 1'b1;
    logic        in_digit_valid = 1'b0;
    logic [3:0]  in_digit = 4'd0;
    logic        in_start = 1'b0;
    logic        in_stop = 1'b0;
    logic        in_door_closed = 1'b1;
    logic [15:0] out_time;
    logic        out_magnetron_on;
    logic        out_done;
    logic [2:0]  out_state;

    int          vectors = 0;
    int          miscompares = 0;
    logic [20:0] sb[$];
    logic [20:0] exp_v;

    microwave_cook_sequencer dut (
        .in_clock         (in_clock),
        .in_reset_n       (in_reset_n),
        .in_sec_clock     (in_sec_clock),
        .in_digit_valid   (in_digit_valid),
        .in_digit         (in_digit),
        .in_start         (in_start),
        .in_stop          (in_stop),
        .in_door_closed   (in_door_closed),
        .out_time         (out_time),
        .out_magnetron_on (out_magnetron_on),
        .out_done         (out_done),
        .out_state        (out_state)
    );

    always #5 in_clock = ~in_clock;

    function automatic logic [20:0] ev(logic [15:0] t, logic [2:0] s, logic d, logic m);
        return {t, s, d, m};
    endfunction

    function automatic logic [20:0] obs();
        return {out_time, out_state, out_done, out_magnetron_on};
    endfunction

    function automatic logic [15:0] secs_to_bcd(int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic cyc();
        @(posedge in_clock);
        #1;
        in_digit_valid = 1'b0;
        in_start = 1'b0;
        in_stop = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        in_digit_valid = 1'b1;
        in_digit = d;
        cyc();
    endtask

    task automatic tick();
        in_sec_clock = 1'b1;
        cyc();
        in_sec_clock = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        in_reset_n = 1'b0;
        in_sec_clock = 1'b1;
        repeat (3) @(posedge in_clock);
        #1;
        sb.push_back(ev(16'h0000, 3'd0, 1'b0, 1'b0));
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL reset_hold got=%h exp=%h", obs(), exp_v); end
        in_reset_n = 1'b1;
        sb.push_back(ev(16'h0000, 3'd0, 1'b0, 1'b0));
        repeat (3) cyc();
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL reset_release got=%h exp=%h", obs(), exp_v); end
        in_sec_clock = 1'b0;
        cyc();
    endtask

    task automatic test_full_cook();
        key(4'd1); key(4'd3);
        sb.push_back(ev(16'h0130, 3'd1, 1'b0, 1'b0));
        key(4'd0);
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL entry_0130 got=%h exp=%h", obs(), exp_v); end
        sb.push_back(ev(16'h0130, 3'd2, 1'b0, 1'b1));
        in_start = 1'b1;
        cyc();
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL start_0130 got=%h exp=%h", obs(), exp_v); end
        for (int k = 1; k <= 90; k++) begin
            int s;
            s = 90 - k;
            sb.push_back(ev(secs_to_bcd(s), (s == 0) ? 3'd4 : 3'd2, s == 0, s != 0));
            tick();
            exp_v = sb.pop_front(); vectors++;
            if (obs() !== exp_v) begin miscompares++; $display("FAIL countdown k=%0d got=%h exp=%h", k, obs(), exp_v); end
        end
        sb.push_back(ev(16'h0000, 3'd4, 1'b1, 1'b0));
        sb.push_back(ev(16'h0000, 3'd0, 1'b0, 1'b0));
        tick(); tick();
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL beep_hold got=%h exp=%h", obs(), exp_v); end
        tick();
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL beep_end got=%h exp=%h", obs(), exp_v); end
    endtask

    task automatic test_door();
        key(4'd1); key(4'd0);
        in_start = 1'b1;
        cyc();
        sb.push_back(ev(16'h0006, 3'd2, 1'b0, 1'b1));
        repeat (4) tick();
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL door_pre got=%h exp=%h", obs(), exp_v); end
        sb.push_back(ev(16'h0006, 3'd2, 1'b0, 1'b0));
        in_door_closed = 1'b0;
        #1;
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL door_power_drop got=%h exp=%h", obs(), exp_v); end
        sb.push_back(ev(16'h0006, 3'd3, 1'b0, 1'b0));
        in_sec_clock = 1'b1;
        cyc();
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL door_with_tick got=%h exp=%h", obs(), exp_v); end
        in_sec_clock = 1'b0;
        cyc();
        sb.push_back(ev(16'h0006, 3'd3, 1'b0, 1'b0));
        repeat (5) tick();
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL door_held got=%h exp=%h", obs(), exp_v); end
        sb.push_back(ev(16'h0006, 3'd2, 1'b0, 1'b1));
        in_door_closed = 1'b1;
        in_start = 1'b1;
        cyc();
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL door_resume got=%h exp=%h", obs(), exp_v); end
        sb.push_back(ev(16'h0001, 3'd2, 1'b0, 1'b1));
        sb.push_back(ev(16'h0000, 3'd4, 1'b1, 1'b0));
        repeat (5) tick();
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL resume_5 got=%h exp=%h", obs(), exp_v); end
        tick();
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL resume_done got=%h exp=%h", obs(), exp_v); end
        in_stop = 1'b1;
        cyc();
    endtask

    task automatic test_quick_start();
        sb.push_back(ev(16'h0030, 3'd2, 1'b0, 1'b1));
        sb.push_back(ev(16'h0030, 3'd3, 1'b0, 1'b0));
        sb.push_back(ev(16'h0000, 3'd0, 1'b0, 1'b0));
        in_start = 1'b1;
        cyc();
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL quick_start got=%h exp=%h", obs(), exp_v); end
        in_stop = 1'b1;
        cyc();
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL quick_pause got=%h exp=%h", obs(), exp_v); end
        in_stop = 1'b1;
        cyc();
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL quick_clear got=%h exp=%h", obs(), exp_v); end
    endtask

    task automatic test_paused_start_tick();
        key(4'd9); key(4'd0);
        in_start = 1'b1;
        cyc();
        in_stop = 1'b1;
        cyc();
        sb.push_back(ev(16'h0090, 3'd2, 1'b0, 1'b1));
        sb.push_back(ev(16'h0089, 3'd2, 1'b0, 1'b1));
        sb.push_back(ev(16'h0089, 3'd2, 1'b0, 1'b1));
        in_start = 1'b1;
        in_sec_clock = 1'b1;
        cyc();
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL resume_with_tick got=%h exp=%h", obs(), exp_v); end
        in_sec_clock = 1'b0;
        cyc();
        tick();
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL nonnorm_dec got=%h exp=%h", obs(), exp_v); end
        key(4'd5);
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL digit_in_cook got=%h exp=%h", obs(), exp_v); end
        in_stop = 1'b1; cyc();
        in_stop = 1'b1; cyc();
    endtask

    task automatic test_stop_start_digits();
        key(4'd4);
        sb.push_back(ev(16'h0000, 3'd0, 1'b0, 1'b0));
        sb.push_back(ev(16'h0000, 3'd0, 1'b0, 1'b0));
        in_stop = 1'b1;
        in_start = 1'b1;
        cyc();
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL stop_beats_start got=%h exp=%h", obs(), exp_v); end
        key(4'd12);
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL digit_gt9 got=%h exp=%h", obs(), exp_v); end
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        sb.push_back(ev(16'h2345, 3'd1, 1'b0, 1'b0));
        sb.push_back(ev(16'h2345, 3'd1, 1'b0, 1'b0));
        key(4'd5);
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL digit_shift got=%h exp=%h", obs(), exp_v); end
        in_door_closed = 1'b0;
        in_start = 1'b1;
        cyc();
        in_door_closed = 1'b1;
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL start_door_open got=%h exp=%h", obs(), exp_v); end
        in_stop = 1'b1;
        cyc();
        key(4'd0);
        sb.push_back(ev(16'h0000, 3'd1, 1'b0, 1'b0));
        in_start = 1'b1;
        cyc();
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL start_zero_entry got=%h exp=%h", obs(), exp_v); end
        in_stop = 1'b1;
        cyc();
    endtask

    task automatic test_done_digit();
        key(4'd1);
        in_start = 1'b1;
        cyc();
        sb.push_back(ev(16'h0000, 3'd4, 1'b1, 1'b0));
        sb.push_back(ev(16'h0007, 3'd1, 1'b0, 1'b0));
        tick();
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL done_from_one got=%h exp=%h", obs(), exp_v); end
        key(4'd7);
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL digit_from_done got=%h exp=%h", obs(), exp_v); end
        in_stop = 1'b1;
        cyc();
    endtask

    task automatic test_reset_mid_cook();
        in_start = 1'b1;
        cyc();
        sb.push_back(ev(16'h0000, 3'd0, 1'b0, 1'b0));
        #2;
        in_reset_n = 1'b0;
        #1;
        exp_v = sb.pop_front(); vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL reset_mid_cook got=%h exp=%h", obs(), exp_v); end
        @(posedge in_clock);
        #1;
        in_reset_n = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_full_cook();
        test_door();
        test_quick_start();
        test_paused_start_tick();
        test_stop_start_digits();
        test_done_digit();
        test_reset_mid_cook();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
